fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage for the RV32I core, directly downstream of the `pc` register. It reads the current PC, issues word-fetch requests to instruction memory over a valid/ready handshake, and computes `pc_next` for the PC register. Responses are paired with their PC and buffered for decode. A redirect from execute flushes every in-flight and buffered fetch.

## Interface
- `DEPTH`, default 4: maximum fetches in flight plus buffered. Power of two, ≥2.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `pc` in 32: current PC from the PC register.
- `pc_next` out 32: next PC, fed to the PC register.
- `redirect_valid` in 1: branch/jump taken; flush.
- `redirect_pc` in 32: redirect target.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_addr` out 32: fetch word address (= `pc`).
- `imem_req_ready` in 1: memory accepts request.
- `imem_rsp_valid` in 1: in-order response valid.
- `imem_rsp_data` in 32: instruction word.
- `inst_valid` out 1: instruction available to decode.
- `inst_data` out 32: instruction.
- `inst_pc` out 32: PC of `inst_data`.
- `inst_ready` in 1: decode accepts.

## Operation
- **Counters:**
  - `outstanding`: accepted requests not yet answered.
  - `discard`: responses still to be dropped.
  - `count`: entries in the instruction FIFO.
- **Credit:** `outstanding + count < DEPTH`.
- **Request:**
  - `imem_req_valid = credit && !redirect_valid && !rst`.
  - `imem_req_addr = pc`.
  - Fire = valid && ready.
- **On fire:** push `pc` into the PC queue (DEPTH entries); `outstanding` +1.
- **pc_next priority:**
  1. `redirect_valid`: `{redirect_pc[31:2], 2'b00}` (low bits forced to zero).
  2. Fire: `pc + 4`, wrapping modulo 2^32.
  3. Otherwise: `pc` (hold).
- **Response with `discard == 0`:** pop the PC queue head, push `{head_pc, imem_rsp_data}` into the instruction FIFO, `outstanding` −1.
- **Response with `discard > 0`:** drop the data, pop the PC queue, `outstanding` −1, `discard` −1.
- **Redirect cycle:**
  - Instruction FIFO cleared.
  - `discard <= outstanding − imem_rsp_valid`; the response arriving that cycle is itself dropped.
  - No request issued.
  - `inst_valid` forced 0, so no pop occurs.
- **Output:** `inst_valid = count != 0 && !redirect_valid`. A pop occurs on `inst_valid && inst_ready`.
- **Protocol violations (out of scope):**
  - A response with `outstanding == 0` is illegal and ignored.
  - FIFO overflow is impossible by the credit rule.
- **Reset:** `outstanding`, `discard`, `count` and the queue pointers go to 0. During `rst`: `imem_req_valid = 0`, `inst_valid = 0`, `pc_next = 0`.

## Timing
- Request is combinational from `pc` and the counters in the same cycle.
- Response earliest 1 cycle after request acceptance; any latency is legal; responses arrive in order.
- Response at edge N → `inst_valid` from cycle N+1.
- With `DEPTH = 4`, 1-cycle memory latency and `inst_ready = 1`, the block sustains one instruction per cycle.
- `inst_data`/`inst_pc` stay stable while `inst_valid && !inst_ready`.
- **Simultaneous events:**
  - Push and pop in the same cycle leave `count` unchanged.
  - Response and redirect in the same cycle: the response is dropped.
  - Fire and redirect cannot coincide.
  - `rst` mid-stream: everything in flight is forgotten, and any later stray response is ignored while `outstanding == 0`.

## Structure
- **Shared package `rv32i_pkg`:**
  - `XLEN = 32`
  - `ILEN = 32`
  - `PC_STEP = 4`
  - typedef `fetch_entry_t` = {pc, inst}
- **Sub-module `sync_fifo`:** parameterised width/depth, synchronous reset, with `clear`. Instantiated twice:
  - PC queue, width 32.
  - Instruction FIFO, width 64.
- Counters and pc_next mux are inline.

## Test plan
- **Reset:** assert `rst` 2 cycles with `pc = 0` → `imem_req_valid = 0`, `inst_valid = 0`, `pc_next = 0`. First request after release has `addr = 0`.
- **Streaming:** `pc` from 0x100, latency 1, `inst_ready = 1` → instructions 0x100, 0x104, 0x108… one per cycle with the correct `inst_pc`. `pc_next = pc + 4` each cycle.
- **Back-pressure:** `inst_ready = 0` → requests stop once `outstanding + count = 4`, `pc_next` holds, and output data stays stable. Releasing `inst_ready` drains in order.
- **Redirect with 2 in flight (latency 3):** redirect to 0x203 → `pc_next = 0x200`. Both stale responses are dropped, the FIFO is emptied, and the first delivered `inst_pc` is 0x200.
- **Redirect in the same cycle as a response and pop** → that response is not delivered and no `inst_valid` is seen that cycle.
- **Wrap-around:** `pc = 0xFFFFFFFC` fired → `pc_next = 0x00000000`.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared RV32I definitions for the fetch path: word sizes, PC step and the
// buffered fetch entry that pairs an instruction with its PC.
package rv32i_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } fetch_entry_t;

    // Instruction fetches are always word aligned.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel plus the decode-side output
// channel of the fetch stage.
interface fetch_unit_if;
    import rv32i_pkg::*;

    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [ILEN-1:0] imem_rsp_data;
    logic            inst_valid;
    logic [ILEN-1:0] inst_data;
    logic [XLEN-1:0] inst_pc;
    logic            inst_ready;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        output inst_valid,
        output inst_data,
        output inst_pc,
        input  inst_ready
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        input  inst_valid,
        input  inst_data,
        input  inst_pc,
        output inst_ready
    );

endinterface

// File: rtl/fetch_unit_sync_fifo.sv
// Small synchronous FIFO with a synchronous clear; the head entry is read
// straight from the array so it is visible the cycle after it is written.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_L = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign do_push = push && (count_q != DEPTH_L);
    assign do_pop  = pop && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign empty     = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage: issues word fetches from the current PC,
// pairs in-order responses with their PC and buffers them for decode.
module fetch_unit
    import rv32i_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_next,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    fetch_unit_if.master    bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_L = (CW + 1)'(DEPTH);

    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [CW-1:0]   inst_count;
    logic [CW-1:0]   pcq_count;
    logic            pcq_empty;
    logic            inst_empty;
    logic [XLEN-1:0] head_pc;
    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;
    logic            credit;
    logic            req_valid;
    logic            fire;
    logic            rsp_accept;
    logic            rsp_keep;
    logic            inst_pop;
    logic            unused_pcq;

    // Buffered plus in-flight fetches may never exceed the buffer depth,
    // which is what makes instruction-FIFO overflow impossible.
    assign credit     = ({1'b0, outstanding_q} + {1'b0, inst_count}) < DEPTH_L;
    assign req_valid  = credit && !redirect_valid && !rst;
    assign fire       = req_valid && bus.imem_req_ready;
    assign rsp_accept = bus.imem_rsp_valid && (outstanding_q != '0);
    assign rsp_keep   = rsp_accept && (discard_q == '0) && !redirect_valid;
    assign inst_pop   = bus.inst_valid && bus.inst_ready;

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc;

    sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_pc_queue (
        .clk       (clk),
        .rst       (rst),
        .clear     (1'b0),
        .push      (fire),
        .push_data (pc),
        .pop       (rsp_accept),
        .head_data (head_pc),
        .count     (pcq_count),
        .empty     (pcq_empty)
    );

    // The PC queue occupancy mirrors outstanding_q by construction.
    assign unused_pcq = ^{pcq_count, pcq_empty};

    assign push_entry.pc   = head_pc;
    assign push_entry.inst = bus.imem_rsp_data;

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_inst_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect_valid),
        .push      (rsp_keep),
        .push_data (push_entry),
        .pop       (inst_pop),
        .head_data (head_entry),
        .count     (inst_count),
        .empty     (inst_empty)
    );

    assign bus.inst_valid = !inst_empty && !redirect_valid && !rst;
    assign bus.inst_data  = head_entry.inst;
    assign bus.inst_pc    = head_entry.pc;

    always_comb begin
        outstanding_d = outstanding_q;
        if (fire && !rsp_accept) begin
            outstanding_d = outstanding_q + CW'(1);
        end else if (!fire && rsp_accept) begin
            outstanding_d = outstanding_q - CW'(1);
        end
    end

    // A redirect turns every request still in flight into a drop, except a
    // response landing in the redirect cycle itself, which is dropped now.
    always_comb begin
        discard_d = discard_q;
        if (redirect_valid) begin
            discard_d = outstanding_q - CW'(rsp_accept);
        end else if (rsp_accept && (discard_q != '0)) begin
            discard_d = discard_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    always_comb begin
        pc_next = pc;
        if (rst) begin
            pc_next = '0;
        end else if (redirect_valid) begin
            pc_next = align_word(redirect_pc);
        end else if (fire) begin
            pc_next = pc + PC_STEP;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a memory model answers requests after a
// configurable latency, and a scoreboard monitor checks every delivered instruction.
module tb_fetch_unit;
    import rv32i_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    fetch_unit_if bus();

    fetch_unit #(.DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc             (pc),
        .pc_next        (pc_next),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_req_t;

    mem_req_t    mem_q[$];
    logic [31:0] exp_q[$];
    int          cyc    = 0;
    int          lat    = 1;
    int          checks = 0;
    int          errors = 0;
    bit          follow = 0;
    logic [31:0] pc_next_s = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], 16'h0013};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one clock; the PC register and the memory response are driven
    // just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (follow) pc = pc_next_s;
        if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(mem_q[0].addr);
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = '0;
        end
    endtask

    // Memory model and scoreboard feed: each accepted request is expected back
    // in order unless a redirect or reset flushes it.
    always @(negedge clk) begin
        if (bus.imem_rsp_valid && mem_q.size() != 0) mem_q.delete(0);
        if (rst || redirect_valid) exp_q.delete();
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            mem_q.push_back('{bus.imem_req_addr, cyc + lat});
            exp_q.push_back(bus.imem_req_addr);
        end
        pc_next_s = pc_next;
    end

    // Monitor: compare every instruction handed to decode against the scoreboard.
    always @(negedge clk) begin
        if (!rst && bus.inst_valid && bus.inst_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_inst: got pc %08h data %08h expected nothing", bus.inst_pc, bus.inst_data);
            end else begin
                $display("inst pc=%08h data=%08h", bus.inst_pc, bus.inst_data);
                chk("mon_inst_pc", bus.inst_pc, exp_q[0]);
                chk("mon_inst_data", bus.inst_data, mem_word(exp_q[0]));
                exp_q.delete(0);
            end
        end
    end

    task automatic do_reset();
        follow = 0;
        redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            rst = 1'b1;
            pc  = '0;
            bus.imem_req_ready = 1'b0;
            #2;
            chk("rst_req_valid", bus.imem_req_valid, 0);
            chk("rst_inst_valid", bus.inst_valid, 0);
            chk("rst_pc_next", pc_next, 0);
        end
        step();
        rst = 1'b0;
        #2;
        chk("rel_req_valid", bus.imem_req_valid, 1);
        chk("rel_req_addr", bus.imem_req_addr, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            #2;
            chk("stray_inst_valid", bus.inst_valid, 0);
        end
        mem_q.delete();
        bus.imem_rsp_valid = 1'b0;
    endtask

    initial begin
        rst                = 1'b1;
        pc                 = '0;
        redirect_valid     = 1'b0;
        redirect_pc        = '0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.inst_ready     = 1'b1;

        do_reset();

        // Streaming from 0x100 with 1-cycle memory, then back-pressure from k=12.
        lat = 1;
        for (int k = 0; k < 18; k++) begin
            step();
            if (k == 0) begin
                pc = 32'h100;
                follow = 1;
            end
            bus.imem_req_ready = 1'b1;
            bus.inst_ready     = (k < 12);
            #2;
            if (k < 14) begin
                chk("stream_addr", bus.imem_req_addr, 32'(32'h100 + 4 * k));
                chk("stream_pc_next", pc_next, 32'(32'h104 + 4 * k));
            end else begin
                chk("bp_req_valid", bus.imem_req_valid, 0);
                chk("bp_pc_next_hold", pc_next, 32'h138);
            end
            if (k < 2) begin
                chk("stream_fill_valid", bus.inst_valid, 0);
            end else if (k < 12) begin
                chk("stream_inst_valid", bus.inst_valid, 1);
                chk("stream_inst_pc", bus.inst_pc, 32'(32'h100 + 4 * (k - 2)));
            end else begin
                chk("bp_inst_valid", bus.inst_valid, 1);
                chk("bp_inst_pc_stable", bus.inst_pc, 32'h128);
                chk("bp_inst_data_stable", bus.inst_data, mem_word(32'h128));
            end
        end
        for (int k = 0; k < 10; k++) begin
            step();
            bus.inst_ready = 1'b1;
            #2;
            if (k == 0) chk("drain_first_pc", bus.inst_pc, 32'h128);
        end

        // Redirects with 3-cycle memory: two in flight, then one with a
        // response and a pop pending in the same cycle.
        do_reset();
        lat = 3;
        for (int k = 0; k < 14; k++) begin
            step();
            if (k == 0) begin
                pc = 32'h300;
                follow = 1;
            end
            bus.imem_req_ready = 1'b1;
            bus.inst_ready     = 1'b1;
            redirect_valid     = (k == 2 || k == 8);
            redirect_pc        = (k == 2) ? 32'h203 : 32'h402;
            #2;
            if (k < 2) chk("redir_pre_addr", bus.imem_req_addr, 32'(32'h300 + 4 * k));
            if (k == 2 || k == 8) begin
                chk("redir_req_valid", bus.imem_req_valid, 0);
                chk("redir_inst_valid", bus.inst_valid, 0);
                chk("redir_pc_next", pc_next, (k == 2) ? 32'h200 : 32'h400);
            end
            if (k >= 3 && k <= 6)  chk("redir_flush_valid", bus.inst_valid, 0);
            if (k >= 9 && k <= 12) chk("redir2_flush_valid", bus.inst_valid, 0);
            if (k == 3) chk("redir_new_addr", bus.imem_req_addr, 32'h200);
            if (k == 9) chk("redir2_new_addr", bus.imem_req_addr, 32'h400);
            if (k == 7) begin
                chk("redir_first_valid", bus.inst_valid, 1);
                chk("redir_first_pc", bus.inst_pc, 32'h200);
            end
            if (k == 13) begin
                chk("redir2_first_valid", bus.inst_valid, 1);
                chk("redir2_first_pc", bus.inst_pc, 32'h400);
            end
        end
        redirect_valid = 1'b0;

        // PC wrap-around at the top of the address space.
        do_reset();
        lat = 1;
        for (int k = 0; k < 5; k++) begin
            step();
            if (k == 0) begin
                pc = 32'hFFFF_FFFC;
                follow = 1;
            end
            bus.imem_req_ready = 1'b1;
            bus.inst_ready     = 1'b1;
            #2;
            if (k == 0) begin
                chk("wrap_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
                chk("wrap_pc_next", pc_next, 32'h0000_0000);
            end
            if (k == 1) chk("wrap_next_addr", bus.imem_req_addr, 32'h0000_0000);
            if (k == 2) begin
                chk("wrap_inst_pc", bus.inst_pc, 32'hFFFF_FFFC);
                chk("wrap_inst_data", bus.inst_data, mem_word(32'hFFFF_FFFC));
            end
            if (k == 3) chk("wrap_after_pc", bus.inst_pc, 32'h0000_0000);
        end

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
